// File: rtl/fft_pkg.sv
// fft_pkg: shared state encoding, result tag and default sizes for the FFT modulus arbiter.
package fft_pkg;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_FRAME_LEN = 1024;
    localparam int DEF_ENG_LAT   = 3;

    typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;

    typedef struct packed {
        logic chan;
        logic sop;
        logic eop;
    } tag_t;
endpackage

// File: rtl/fft_tag_delay.sv
// fft_tag_delay: DEPTH-deep shift register carrying a result tag and valid alongside the engine.
module fft_tag_delay
    import fft_pkg::*;
#(
    parameter int DEPTH = DEF_ENG_LAT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  tag_t i_tag,
    input  logic i_valid,
    output tag_t o_tag,
    output logic o_valid
);
    tag_t             r_tag [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
            r_valid <= '0;
        end else begin
            r_tag[0]   <= i_tag;
            r_valid[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_tag[i]   <= r_tag[i-1];
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    assign o_tag   = r_tag[DEPTH-1];
    assign o_valid = r_valid[DEPTH-1];
endmodule

// File: rtl/fft_mod_arbiter.sv
// fft_mod_arbiter: frame-level round-robin sharing of one FFT modulus engine between two channels.
// Defining FFT_ARB_ERRCNT_EN adds o_err_cnt, a saturating count of frame_err pulses.
module fft_mod_arbiter
    import fft_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int ENG_LAT   = DEF_ENG_LAT
) (
    input  logic              i_clk_50m,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_ch0_real,
    input  logic [DATA_W-1:0] i_ch0_imag,
    input  logic              i_ch0_sop,
    input  logic              i_ch0_eop,
    input  logic              i_ch0_valid,
    output logic              o_ch0_ready,
    input  logic [DATA_W-1:0] i_ch1_real,
    input  logic [DATA_W-1:0] i_ch1_imag,
    input  logic              i_ch1_sop,
    input  logic              i_ch1_eop,
    input  logic              i_ch1_valid,
    output logic              o_ch1_ready,
    output logic [DATA_W-1:0] o_eng_real,
    output logic [DATA_W-1:0] o_eng_imag,
    output logic              o_eng_valid,
    input  logic [DATA_W-1:0] i_eng_modulus,
    input  logic              i_eng_valid_o,
    output logic [DATA_W-1:0] o_mod_data,
    output logic              o_mod_valid,
    output logic              o_mod_sop,
    output logic              o_mod_eop,
    output logic              o_mod_chan,
`ifdef FFT_ARB_ERRCNT_EN
    output logic [15:0]       o_err_cnt,
`endif
    output logic              o_frame_err
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    state_t      r_state;
    logic        r_last;
    logic [CW-1:0] r_cnt;
    tag_t        r_tag;
    tag_t        w_tag;
    tag_t        w_tag_o;
    logic        w_tvalid;
    logic        w_req0, w_req1, w_acc0, w_acc1, w_sel, w_beat, w_last, w_end, w_err, w_grant1;
    logic        w_sop, w_eop;
    logic [DATA_W-1:0] w_real, w_imag;

    assign w_req0      = i_ch0_valid & i_ch0_sop;
    assign w_req1      = i_ch1_valid & i_ch1_sop;
    // In IDLE only stray (non-SOP) beats are taken, so a request's SOP beat waits for its grant
    assign o_ch0_ready = (r_state == SERVE0) | ((r_state == IDLE) & i_ch0_valid & ~i_ch0_sop);
    assign o_ch1_ready = (r_state == SERVE1) | ((r_state == IDLE) & i_ch1_valid & ~i_ch1_sop);
    assign w_acc0      = i_ch0_valid & o_ch0_ready;
    assign w_acc1      = i_ch1_valid & o_ch1_ready;
    assign w_sel       = r_state == SERVE1;
    assign w_real      = w_sel ? i_ch1_real : i_ch0_real;
    assign w_imag      = w_sel ? i_ch1_imag : i_ch0_imag;
    assign w_sop       = w_sel ? i_ch1_sop : i_ch0_sop;
    assign w_eop       = w_sel ? i_ch1_eop : i_ch0_eop;
    assign w_beat      = ((r_state == SERVE0) & w_acc0) | ((r_state == SERVE1) & w_acc1);
    assign w_last      = r_cnt == CW'(FRAME_LEN - 1);
    assign w_end       = w_beat & (w_eop | w_last);
    assign w_err       = ((r_state == IDLE) & (w_acc0 | w_acc1))
                       | (w_beat & ((w_sop & (r_cnt != '0)) | (w_last & ~w_eop)));
    assign w_grant1    = w_req1 & (~w_req0 | ~r_last);
    assign w_tag       = w_beat ? tag_t'({w_sel, w_sop & (r_cnt == '0), w_eop | w_last}) : '0;

    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_cnt       <= '0;
            r_tag       <= '0;
            o_eng_real  <= '0;
            o_eng_imag  <= '0;
            o_eng_valid <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= w_err;
            o_eng_valid <= w_beat;
            r_tag       <= w_tag;
            if (w_beat) begin
                o_eng_real <= w_real;
                o_eng_imag <= w_imag;
            end
            if (w_end) r_last <= w_sel;
            r_cnt   <= w_end ? '0 : r_cnt + CW'(w_beat);
            r_state <= (r_state == IDLE) ? ((w_req0 | w_req1) ? (w_grant1 ? SERVE1 : SERVE0) : IDLE)
                                         : (w_end ? IDLE : r_state);
        end
    end

    fft_tag_delay #(.DEPTH(ENG_LAT)) u_tag_delay (
        .i_clk   (i_clk_50m),
        .i_rst_n (i_rst_n),
        .i_tag   (r_tag),
        .i_valid (o_eng_valid),
        .o_tag   (w_tag_o),
        .o_valid (w_tvalid)
    );

    assign o_mod_data  = i_eng_modulus;
    assign o_mod_valid = i_eng_valid_o;
    assign o_mod_chan  = i_eng_valid_o & w_tvalid & w_tag_o.chan;
    assign o_mod_sop   = i_eng_valid_o & w_tvalid & w_tag_o.sop;
    assign o_mod_eop   = i_eng_valid_o & w_tvalid & w_tag_o.eop;

`ifdef FFT_ARB_ERRCNT_EN
    always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
        if (!i_rst_n) o_err_cnt <= '0;
        else if (o_frame_err && o_err_cnt != 16'hFFFF) o_err_cnt <= o_err_cnt + 16'd1;
    end
`endif
endmodule
